cav_iq_demod: RTL and testbench

- Coherent IQ demodulator directly downstream of the cavity model; consumes its signed 16-bit `cav` stream.
- Multiplies each sample by a cos/sin LO at RF_NUM/DEN of the sample rate.
- Integrates over one full coherent period (DEN samples) and emits one I/Q pair per period with a strobe.
- Feeds the amplitude/phase readback and feedback stages.

---
 rtl/cav_iq_demod.sv | 168 ++++++++++++++++
 tb/tb_cav_iq_demod.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cav_iq_demod.sv
// Coherent IQ demodulator for the cavity sample stream.
// Each accepted sample is mixed with a cos/sin LO stepping RF_NUM/DEN of the
// sample rate. Products are integrated over one coherent frame of DEN samples,
// and one scaled, saturated I/Q pair is emitted per frame with a strobe.
module cav_iq_demod #(
  parameter int RF_NUM = 7,
  parameter int DEN    = 33,
  parameter int LO_AMP = 32767,
  parameter int ACC_W  = 40,
  parameter int SHIFT  = 17,
  parameter int OUT_W  = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  input  logic             phase_reset,
  output logic [OUT_W-1:0] i_out,
  output logic [OUT_W-1:0] q_out,
  output logic             out_strobe,
  output logic             overflow
);

  localparam int  KW      = (DEN > 1) ? $clog2(DEN) : 1;
  localparam int  RF_STEP = RF_NUM % DEN;
  localparam real PI      = 3.14159265358979323846;

  localparam logic signed [ACC_W-1:0] OUT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // LO table entry, rounded half away from zero.
  function automatic logic signed [15:0] lo_entry(input int idx, input bit use_sin);
    real ang;
    real v;
    int  r;
    ang = 2.0 * PI * $itor(idx) / $itor(DEN);
    v   = use_sin ? $itor(LO_AMP) * $sin(ang) : $itor(LO_AMP) * $cos(ang);
    r   = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return 16'(r);
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic signed [31:0] p);
    return {{(ACC_W-32){p[31]}}, p};
  endfunction

  // Arithmetic shift: truncates toward minus infinity.
  function automatic logic signed [ACC_W-1:0] scale(input logic signed [ACC_W-1:0] a);
    return a >>> SHIFT;
  endfunction

  function automatic logic is_clip(input logic signed [ACC_W-1:0] v);
    return (v > OUT_MAX) || (v < OUT_MIN);
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [ACC_W-1:0] v);
    if (v > OUT_MAX) return OUT_MAX[OUT_W-1:0];
    if (v < OUT_MIN) return OUT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  logic signed [15:0] cos_tab [DEN];
  logic signed [15:0] sin_tab [DEN];

  for (genvar g = 0; g < DEN; g++) begin : g_lo
    assign cos_tab[g] = lo_entry(g, 1'b0);
    assign sin_tab[g] = lo_entry(g, 1'b1);
  end

  logic [KW-1:0] k_q, k_d, n_q, n_d, k_sel;
  logic [KW:0]   k_sum;
  logic          last_sel;

  logic signed [15:0]      x_p0, cos_p0, sin_p0;
  logic                    last_p0, vld_p0;
  logic signed [31:0]      prod_i_p1, prod_q_p1;
  logic                    last_p1, vld_p1;
  logic signed [ACC_W-1:0] acc_i_q, acc_q_q;
  logic signed [ACC_W-1:0] sum_i_p2, sum_q_p2;
  logic                    vld_p2;
  logic signed [OUT_W-1:0] i_out_q, q_out_q;
  logic                    strobe_q, ovf_q;

  // Next LO index (modulo DEN without wrap-around) and next frame position.
  always_comb begin
    k_sum = {1'b0, k_q} + (KW+1)'(RF_STEP);
    k_d   = k_sum[KW-1:0];
    if (k_sum >= (KW+1)'(DEN)) k_d = KW'(k_sum - (KW+1)'(DEN));
    n_d   = (n_q == KW'(DEN-1)) ? '0 : n_q + KW'(1);
  end

  // A phase_reset sample is taken as sample 0 of a fresh frame.
  assign k_sel    = phase_reset ? '0 : k_q;
  assign last_sel = !phase_reset && (n_q == KW'(DEN-1));

  // Control path: LO phase, frame position, valids, outputs and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q      <= '0;
      n_q      <= '0;
      vld_p0   <= 1'b0;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      i_out_q  <= '0;
      q_out_q  <= '0;
    end else if (phase_reset) begin
      k_q      <= in_valid ? KW'(RF_STEP) : '0;
      n_q      <= in_valid ? KW'(1) : '0;
      vld_p0   <= in_valid;
      vld_p1   <= 1'b0;
      vld_p2   <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      if (in_valid) begin
        k_q <= k_d;
        n_q <= n_d;
      end
      vld_p0   <= in_valid;
      vld_p1   <= vld_p0;
      vld_p2   <= vld_p1 && last_p1;
      strobe_q <= vld_p2;
      if (vld_p2) begin
        i_out_q <= sat_out(scale(sum_i_p2));
        q_out_q <= sat_out(scale(sum_q_p2));
        ovf_q   <= ovf_q | is_clip(scale(sum_i_p2)) | is_clip(scale(sum_q_p2));
      end
    end
  end

  // Integrators: cleared on reset/phase restart and at every frame end.
  always_ff @(posedge clk) begin
    if (rst || phase_reset) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
    end else if (vld_p1) begin
      if (last_p1) begin
        acc_i_q <= '0;
        acc_q_q <= '0;
      end else begin
        acc_i_q <= acc_i_q + sext(prod_i_p1);
        acc_q_q <= acc_q_q + sext(prod_q_p1);
      end
    end
  end

  // Datapath registers; qualified by the valids, so no reset.
  always_ff @(posedge clk) begin
    // p0: sample with its LO pair and frame-last flag
    x_p0      <= $signed(in_data);
    cos_p0    <= cos_tab[k_sel];
    sin_p0    <= sin_tab[k_sel];
    last_p0   <= last_sel;
    // p1: mixer products
    prod_i_p1 <= 32'(x_p0) * 32'(cos_p0);
    prod_q_p1 <= 32'(x_p0) * 32'(sin_p0);
    last_p1   <= last_p0;
    // p2: completed frame sum including the last product
    sum_i_p2  <= acc_i_q + sext(prod_i_p1);
    sum_q_p2  <= acc_q_q + sext(prod_q_p1);
  end

  assign i_out      = i_out_q;
  assign q_out      = q_out_q;
  assign out_strobe = strobe_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_cav_iq_demod.sv
// Testbench for cav_iq_demod: scenario tasks compare observed strobes against
// a frame-level arithmetic model of the demodulator.
module tb_cav_iq_demod;

  localparam int  RF_NUM = 7;
  localparam int  DEN    = 33;
  localparam int  LO_AMP = 32767;
  localparam int  ACC_W  = 40;
  localparam int  SHIFT  = 17;
  localparam int  OUT_W  = 18;
  localparam real PI     = 3.14159265358979323846;
  localparam int  OMAX   = (1 <<< (OUT_W-1)) - 1;
  localparam int  OMIN   = -(1 <<< (OUT_W-1));

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    phase_reset = 1'b0;
  logic [15:0]             in_data = '0;
  logic signed [OUT_W-1:0] i_out, q_out;
  logic                    out_strobe, overflow;

  cav_iq_demod #(.RF_NUM(RF_NUM), .DEN(DEN), .LO_AMP(LO_AMP), .ACC_W(ACC_W),
                 .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .phase_reset(phase_reset), .i_out(i_out), .q_out(q_out),
    .out_strobe(out_strobe), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed { int cyc; int i; int q; } ev_t;
  ev_t     obs_q[$];
  ev_t     exp_q[$];
  int      checks = 0;
  int      failures = 0;
  int      tcyc = 0;
  longint  m_i = 0, m_q = 0;
  int      m_n = 0;
  bit      m_ovf = 1'b0;

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
  endfunction

  function automatic int lo(input int k, input bit s);
    real a;
    a = 2.0 * PI * $itor(k) / $itor(DEN);
    return rnd($itor(LO_AMP) * (s ? $sin(a) : $cos(a)));
  endfunction

  function automatic int wave(input int amp, input int n, input bit s);
    real a;
    a = 2.0 * PI * $itor(RF_NUM * n) / $itor(DEN);
    return rnd($itor(amp) * (s ? $sin(a) : $cos(a)));
  endfunction

  function automatic int sat(input longint v);
    if (v > OMAX) return OMAX;
    if (v < OMIN) return OMIN;
    return int'(v);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // One clock: drive, update the frame model at the edge, record any strobe.
  task automatic step(input bit v, input int d, input bit pr, input bit r);
    ev_t    e;
    int     kk;
    longint si, sq;
    in_valid = v; in_data = d[15:0]; phase_reset = pr; rst = r;
    @(posedge clk);
    tcyc++;
    if (r || pr) begin
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= tcyc) void'(exp_q.pop_back());
      m_n = 0; m_i = 0; m_q = 0;
      if (r) m_ovf = 1'b0;
    end
    if (!r && v) begin
      kk  = (RF_NUM * m_n) % DEN;
      m_i += longint'(d) * longint'(lo(kk, 1'b0));
      m_q += longint'(d) * longint'(lo(kk, 1'b1));
      m_n++;
      if (m_n == DEN) begin
        si = m_i >>> SHIFT;
        sq = m_q >>> SHIFT;
        if (si > OMAX || si < OMIN || sq > OMAX || sq < OMIN) m_ovf = 1'b1;
        e = '{tcyc + 3, sat(si), sat(sq)};
        exp_q.push_back(e);
        m_n = 0; m_i = 0; m_q = 0;
      end
    end
    #1;
    if (out_strobe === 1'b1) obs_q.push_back('{tcyc, int'(i_out), int'(q_out)});
  endtask

  task automatic drain(input int n);
    for (int j = 0; j < n; j++) step(1'b0, int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0);
  endtask

  task automatic begin_frame();
    step(1'b0, 0, 1'b1, 1'b0);
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    for (int j = 0; j < 3; j++) begin
      step(1'b1, 30000, 1'b0, 1'b1);
      checks++;
      if (out_strobe !== 1'b0 || i_out !== '0 || q_out !== '0 || overflow !== 1'b0) begin
        failures++;
        $display("FAIL reset_state got strobe=%b i=%0d q=%0d ovf=%b want 0 0 0 0",
                 out_strobe, i_out, q_out, overflow);
      end
    end
    obs_q.delete(); exp_q.delete();
    for (int j = 0; j < DEN; j++) step(1'b1, 30000, 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != exp_q.size() || obs_q.size() != 1) begin
      failures++;
      $display("FAIL reset_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin
        failures++;
        $display("FAIL reset_frame%0d got cyc=%0d i=%0d q=%0d want cyc=%0d i=%0d q=%0d", j,
                 obs_q[j].cyc, obs_q[j].i, obs_q[j].q, exp_q[j].cyc, exp_q[j].i, exp_q[j].q);
      end
    end
  endtask

  task automatic test_dc();
    int t0;
    begin_frame();
    t0 = tcyc;
    for (int j = 0; j < 5 * DEN; j++) step(1'b1, 1000, 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != 5) begin
      failures++;
      $display("FAIL dc_count got=%0d want=5", obs_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin
        failures++;
        $display("FAIL dc_frame%0d got cyc=%0d i=%0d q=%0d want cyc=%0d i=%0d q=%0d", j,
                 obs_q[j].cyc, obs_q[j].i, obs_q[j].q, exp_q[j].cyc, exp_q[j].i, exp_q[j].q);
      end
      checks++;
      if (!((obs_q[j].i == 0 || obs_q[j].i == -1) && (obs_q[j].q == 0 || obs_q[j].q == -1))) begin
        failures++;
        $display("FAIL dc_reject%0d got i=%0d q=%0d want each in {-1,0}", j, obs_q[j].i, obs_q[j].q);
      end
    end
    if (obs_q.size() > 0) begin
      checks++;
      if (obs_q[0].cyc != t0 + DEN + 3) begin
        failures++;
        $display("FAIL dc_latency got=%0d want=%0d", obs_q[0].cyc, t0 + DEN + 3);
      end
    end
    for (int j = 1; j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j].cyc - obs_q[j-1].cyc != DEN) begin
        failures++;
        $display("FAIL dc_spacing%0d got=%0d want=%0d", j, obs_q[j].cyc - obs_q[j-1].cyc, DEN);
      end
    end
  endtask

  task automatic test_cosine();
    begin_frame();
    for (int n = 0; n < DEN; n++) step(1'b1, wave(30000, n, 1'b0), 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL cos_count got=%0d want=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== exp_q[0]) begin
        failures++;
        $display("FAIL cos_model got cyc=%0d i=%0d q=%0d want cyc=%0d i=%0d q=%0d",
                 obs_q[0].cyc, obs_q[0].i, obs_q[0].q, exp_q[0].cyc, exp_q[0].i, exp_q[0].q);
      end
      checks++;
      if (iabs(obs_q[0].i - 123746) > 2 || iabs(obs_q[0].q) > 2) begin
        failures++;
        $display("FAIL cos_value got i=%0d q=%0d want i=123746+-2 q=0+-2", obs_q[0].i, obs_q[0].q);
      end
    end
  endtask

  task automatic test_sine_gapped();
    begin_frame();
    for (int n = 0; n < 2 * DEN; n++) begin
      step(1'b1, wave(30000, n, 1'b1), 1'b0, 1'b0);
      step(1'b0, int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0);
    end
    drain(5);
    checks++;
    if (obs_q.size() != 2 || exp_q.size() != 2) begin
      failures++;
      $display("FAIL sin_count got=%0d want=2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[1].cyc - obs_q[0].cyc != 2 * DEN) begin
        failures++;
        $display("FAIL sin_period got=%0d want=%0d", obs_q[1].cyc - obs_q[0].cyc, 2 * DEN);
      end
      for (int j = 0; j < 2; j++) begin
        checks++;
        if (obs_q[j] !== exp_q[j] || iabs(obs_q[j].q - 123746) > 2 || iabs(obs_q[j].i) > 2) begin
          failures++;
          $display("FAIL sin_frame%0d got cyc=%0d i=%0d q=%0d want cyc=%0d i=%0d q=%0d", j,
                   obs_q[j].cyc, obs_q[j].i, obs_q[j].q, exp_q[j].cyc, exp_q[j].i, exp_q[j].q);
        end
      end
    end
  endtask

  task automatic test_saturation();
    begin_frame();
    for (int n = 0; n < DEN; n++) step(1'b1, wave(32767, n, 1'b0), 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].i != OMAX || overflow !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos got n=%0d i=%0d ovf=%b want n=1 i=%0d ovf=1",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].i : 0, overflow, OMAX);
    end
    begin_frame();
    for (int n = 0; n < DEN; n++) step(1'b1, 100, 1'b0, 1'b0);
    drain(5);
    checks++;
    if (overflow !== 1'b1 || obs_q.size() != 1 || exp_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      failures++;
      $display("FAIL sat_sticky got ovf=%b n=%0d want ovf=1 n=1 matching model", overflow, obs_q.size());
    end
    begin_frame();
    for (int n = 0; n < DEN; n++) step(1'b1, wave(-32767, n, 1'b0), 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != 1 || obs_q[0].i != OMIN || overflow !== m_ovf) begin
      failures++;
      $display("FAIL sat_neg got n=%0d i=%0d ovf=%b want n=1 i=%0d ovf=%b",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0].i : 0, overflow, OMIN, m_ovf);
    end
    step(1'b1, 500, 1'b0, 1'b1);
    checks++;
    if (overflow !== 1'b0 || i_out !== '0 || q_out !== '0 || out_strobe !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear got ovf=%b i=%0d q=%0d strobe=%b want 0 0 0 0",
               overflow, i_out, q_out, out_strobe);
    end
  endtask

  task automatic test_phase_reset();
    int  t_pr;
    real mag;
    begin_frame();
    for (int n = 0; n < 15; n++) step(1'b1, wave(30000, n, 1'b0), 1'b0, 1'b0);
    step(1'b1, wave(30000, 0, 1'b0), 1'b1, 1'b0);
    t_pr = tcyc;
    for (int n = 1; n < DEN; n++) step(1'b1, wave(30000, n, 1'b0), 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL pr_sync_count got=%0d want=1", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0].cyc != t_pr + DEN - 1 + 3 || obs_q[0] !== exp_q[0] ||
          iabs(obs_q[0].i - 123746) > 2 || iabs(obs_q[0].q) > 2) begin
        failures++;
        $display("FAIL pr_sync got cyc=%0d i=%0d q=%0d want cyc=%0d i=%0d q=%0d",
                 obs_q[0].cyc, obs_q[0].i, obs_q[0].q, t_pr + DEN + 2, exp_q[0].i, exp_q[0].q);
      end
    end
    begin_frame();
    for (int n = 0; n < 15; n++) step(1'b1, wave(30000, n, 1'b0), 1'b0, 1'b0);
    step(1'b1, wave(30000, 15, 1'b0), 1'b1, 1'b0);
    for (int n = 16; n < 15 + DEN; n++) step(1'b1, wave(30000, n, 1'b0), 1'b0, 1'b0);
    drain(5);
    checks++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      failures++;
      $display("FAIL pr_rot_count got=%0d want=1", obs_q.size());
    end else begin
      mag = $sqrt($itor(obs_q[0].i) * $itor(obs_q[0].i) + $itor(obs_q[0].q) * $itor(obs_q[0].q));
      checks++;
      if (obs_q[0] !== exp_q[0] || mag < 123742.0 || mag > 123750.0) begin
        failures++;
        $display("FAIL pr_rot got i=%0d q=%0d want i=%0d q=%0d magnitude near 123746",
                 obs_q[0].i, obs_q[0].q, exp_q[0].i, exp_q[0].q);
      end
    end
  endtask

  task automatic test_random();
    begin_frame();
    for (int j = 0; j < 600; j++) begin
      step($urandom_range(0, 9) < 7, int'($urandom_range(0, 65535)) - 32768,
           $urandom_range(0, 99) == 0, j == 300);
    end
    drain(5);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got=%0d want=%0d", obs_q.size(), exp_q.size());
    end
    for (int j = 0; j < exp_q.size() && j < obs_q.size(); j++) begin
      checks++;
      if (obs_q[j] !== exp_q[j]) begin
        failures++;
        $display("FAIL rand_frame%0d got cyc=%0d i=%0d q=%0d want cyc=%0d i=%0d q=%0d", j,
                 obs_q[j].cyc, obs_q[j].i, obs_q[j].q, exp_q[j].cyc, exp_q[j].i, exp_q[j].q);
      end
    end
    checks++;
    if (overflow !== m_ovf) begin
      failures++;
      $display("FAIL rand_overflow got=%b want=%b", overflow, m_ovf);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_dc();
    test_cosine();
    test_sine_gapped();
    test_saturation();
    test_phase_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
